// File: rtl/seg7_scan_display_pkg.sv
// rtl/seg7_scan_display_pkg.sv - view encodings, segment constants and view mux for the debug display
// Purpose: shared definitions for seg7_scan_display and hex_to_seg7.
// Contents: view_e select encoding, hex7 segment patterns (gfedcba, active low),
//           blank pattern, and the combinational view-word helper.
package seg7_scan_display_pkg;

  typedef enum logic [1:0] {
    VIEW_PC_RES = 2'b00,
    VIEW_RS_RT  = 2'b01,
    VIEW_RES16  = 2'b10,
    VIEW_PC16   = 2'b11
  } view_e;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b0000011;
  localparam logic [6:0] SEG_C     = 7'b1000110;
  localparam logic [6:0] SEG_D     = 7'b0100001;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_F     = 7'b0001110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Two-byte views pack the low bytes of two CPU values; 16-bit views show one value.
  function automatic logic [15:0] view_word(input view_e      view,
                                            input logic [15:0] pc,
                                            input logic [15:0] rs,
                                            input logic [15:0] rt,
                                            input logic [15:0] res);
    logic [15:0] w;
    w = 16'h0000;
    case (view)
      VIEW_PC_RES: w = {pc[7:0], res[7:0]};
      VIEW_RS_RT:  w = {rs[7:0], rt[7:0]};
      VIEW_RES16:  w = res;
      VIEW_PC16:   w = pc;
      default:     w = 16'h0000;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to seven-segment decoder
// Purpose: decode one 4-bit value to an active-low gfedcba segment pattern.
// Ports: nibble (in, 4) value to show; seg (out, 7) segments {g,f,e,d,c,b,a}, active low.
module hex_to_seg7
  import seg7_scan_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// rtl/seg7_scan_display.sv - 4-digit multiplexed hex display of a selected CPU debug view
// Purpose: scan a 16-bit view of the CPU outputs onto a common-anode 4-digit display,
//          sampling the view once per frame so a frame never mixes old and new data.
// Ports: CLK, Reset (async, active high); sel (view select); curPC, Out1, Out2, Result (CPU values);
//        an (digit enables, active low, an[0] rightmost); seg ({g..a}, active low); dp (active low).
module seg7_scan_display
  import seg7_scan_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic [1:0]  sel,
  input  logic [31:0] curPC,
  input  logic [31:0] Out1,
  input  logic [31:0] Out2,
  input  logic [31:0] Result,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int              DIV_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);

  logic [DIV_W-1:0] div;
  logic [1:0]       idx;
  logic [15:0]      snap;
  logic [1:0]       snap_sel;

  logic             tick;
  logic [1:0]       idx_next;
  logic [15:0]      snap_next;
  logic [1:0]       sel_next;
  logic [3:0]       nibble;
  logic [6:0]       seg_dec;
  logic [3:0]       an_next;
  logic             dp_next;
  logic [15:0]      live_word;

  // Upper halves of the CPU values never reach the display.
  logic unused_hi;
  assign unused_hi = ^{curPC[31:16], Out1[31:16], Out2[31:16], Result[31:16]};

  assign live_word = view_word(view_e'(sel), curPC[15:0], Out1[15:0], Out2[15:0], Result[15:0]);

  always_comb begin
    tick     = (div == DIV_MAX);
    idx_next = idx + 2'd1;
    // Frame boundary: the edge leaving digit 3 loads the snapshot that digit 0 shows next.
    if (idx == 2'd3) begin
      snap_next = live_word;
      sel_next  = sel;
    end else begin
      snap_next = snap;
      sel_next  = snap_sel;
    end
    nibble  = 4'(snap_next >> {idx_next, 2'b00});
    an_next = ~(4'b0001 << idx_next);
    // Byte separator between the two bytes of the packed two-byte views.
    dp_next = ~((idx_next == 2'd2) && !sel_next[1]);
  end

  hex_to_seg7 u_hex (
    .nibble (nibble),
    .seg    (seg_dec)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      div      <= '0;
      idx      <= 2'd3;
      snap     <= 16'h0000;
      snap_sel <= 2'b00;
      an       <= 4'b1111;
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      div <= tick ? '0 : div + 1'b1;
      if (tick) begin
        idx      <= idx_next;
        snap     <= snap_next;
        snap_sel <= sel_next;
        an       <= an_next;
        seg      <= seg_dec;
        dp       <= dp_next;
      end
    end
  end

endmodule
